// File: rtl/flag_sync_rx_multi.sv
// flag_sync_rx_multi
//   Multi-channel receiver for toggle-encoded event flags. Each TOGGLE_IN line
//   is brought into the CLK domain through a SYNC_STAGES-deep synchroniser.
//   Each edge on a line becomes one registered FLAG_OUT pulse. A saturating
//   per-channel event counter with a sticky overflow bit can be read back.
//   Flags stay suppressed until the synchronisers have been primed after reset.
//
// Ports
//   CLK        : clock; all state updates on posedge
//   RST        : synchronous reset, active-high
//   CE         : clock enable for synchroniser shift, priming and detection
//   TOGGLE_IN  : asynchronous toggle lines, one per channel
//   FLAG_OUT   : registered one-cycle pulse per detected event
//   ANY_FLAG   : combinational OR of FLAG_OUT
//   ARMED      : high once priming has completed after reset
//   CNT_CLEAR  : per-channel clear of counter and overflow (ignores CE)
//   EVENT_CNT  : saturating counters, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   OVERFLOW   : sticky, set by an event arriving while the counter is saturated
module flag_sync_rx_multi #(
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned SYNC_STAGES = 3,
   parameter int unsigned CNT_WIDTH   = 8
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          CE,
   input  logic [CHANNELS-1:0]           TOGGLE_IN,
   output logic [CHANNELS-1:0]           FLAG_OUT,
   output logic                          ANY_FLAG,
   output logic                          ARMED,
   input  logic [CHANNELS-1:0]           CNT_CLEAR,
   output logic [CHANNELS*CNT_WIDTH-1:0] EVENT_CNT,
   output logic [CHANNELS-1:0]           OVERFLOW
);

   localparam int unsigned         PW         = $clog2(SYNC_STAGES + 1);
   localparam logic [PW-1:0]       PRIME_LAST = PW'(SYNC_STAGES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   typedef enum logic {
      ST_PRIMING = 1'b0,
      ST_ARMED   = 1'b1
   } state_t;

   // Stage 0 is the metastability-capture flop; keep the whole chain as
   // discrete flops rather than a shift-register primitive.
   (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
   logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0]  sync_d [SYNC_STAGES];
   logic [PW-1:0]        prime_q, prime_d;
   state_t               state_q, state_d;
   logic [CHANNELS-1:0]  flag_q, flag_d;
   logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
   logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];
   logic [CHANNELS-1:0]  ovf_q, ovf_d;

   always_comb begin
      sync_d  = sync_q;
      prime_d = prime_q;
      state_d = state_q;
      flag_d  = '0;
      if (CE) begin
         sync_d[0] = TOGGLE_IN;
         for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
         end
         // Detection uses the pre-edge armed state, so the priming edge
         // that sets ARMED emits nothing.
         if (state_q == ST_PRIMING) begin
            prime_d = prime_q + PW'(1);
            if (prime_q == PRIME_LAST) begin
               state_d = ST_ARMED;
            end
         end else begin
            flag_d = sync_q[SYNC_STAGES-2] ^ sync_q[SYNC_STAGES-1];
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (CNT_CLEAR[i]) begin
            // A clear colliding with an event keeps that event.
            cnt_d[i] = CNT_WIDTH'(flag_d[i]);
            ovf_d[i] = 1'b0;
         end else if (flag_d[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               ovf_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            cnt_q[i] <= '0;
         end
         prime_q <= '0;
         state_q <= ST_PRIMING;
         flag_q  <= '0;
         ovf_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         prime_q <= prime_d;
         state_q <= state_d;
         flag_q  <= flag_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      EVENT_CNT = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         EVENT_CNT[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
      end
   end

   assign FLAG_OUT = flag_q;
   assign ANY_FLAG = |flag_q;
   assign ARMED    = (state_q == ST_ARMED);
   assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_flag_sync_rx_multi.sv
// tb_flag_sync_rx_multi
//   Directed bench for flag_sync_rx_multi with default parameters
//   (4 channels, 3 sync stages, 8-bit counters).
module tb_flag_sync_rx_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic [3:0]  toggle_in;
   logic [3:0]  flag_out;
   logic        any_flag;
   logic        armed;
   logic [3:0]  cnt_clear;
   logic [31:0] event_cnt;
   logic [3:0]  overflow;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   flag_sync_rx_multi #(
      .CHANNELS   (4),
      .SYNC_STAGES(3),
      .CNT_WIDTH  (8)
   ) dut (
      .CLK      (clk),
      .RST      (rst),
      .CE       (ce),
      .TOGGLE_IN(toggle_in),
      .FLAG_OUT (flag_out),
      .ANY_FLAG (any_flag),
      .ARMED    (armed),
      .CNT_CLEAR(cnt_clear),
      .EVENT_CNT(event_cnt),
      .OVERFLOW (overflow)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst       = 1'b1;
      ce        = 1'b0;
      toggle_in = 4'b1111;
      cnt_clear = 4'b0000;
      tick();
      tick();
      check("rst_armed", 32'(armed), 32'd0);
      check("rst_flag", 32'(flag_out), 32'd0);
      check("rst_cnt", event_cnt, 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);

      // Priming with all lines high through reset
      rst = 1'b0;
      ce  = 1'b1;
      tick();
      check("prime_e1_armed", 32'(armed), 32'd0);
      tick();
      check("prime_e2_armed", 32'(armed), 32'd0);
      check("prime_e2_flag", 32'(flag_out), 32'd0);
      tick();
      check("prime_e3_armed", 32'(armed), 32'd1);
      check("prime_e3_flag", 32'(flag_out), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("prime_post_flag", 32'(flag_out), 32'd0);
      end
      check("prime_cnt", event_cnt, 32'd0);

      // Re-prime with lines low
      toggle_in = 4'b0000;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      tick();
      tick();
      check("reprime_armed", 32'(armed), 32'd1);
      tick();
      check("reprime_flag", 32'(flag_out), 32'd0);

      // Single event on channel 2
      toggle_in = 4'b0100;
      tick();
      check("single_e1", 32'(flag_out), 32'd0);
      tick();
      check("single_e2", 32'(flag_out), 32'd0);
      tick();
      check("single_e3_flag", 32'(flag_out), 32'h4);
      check("single_e3_any", 32'(any_flag), 32'd1);
      check("single_cnt", event_cnt, 32'h0001_0000);
      tick();
      check("single_e4_flag", 32'(flag_out), 32'd0);
      check("single_e4_any", 32'(any_flag), 32'd0);

      // Sparse CE: one CE edge in every four cycles
      toggle_in = 4'b0101;
      for (int e = 1; e <= 4; e++) begin
         ce = 1'b1;
         tick();
         ce = 1'b0;
         check("sparse_ce_flag", 32'(flag_out), (e == 3) ? 32'h1 : 32'h0);
         for (int j = 0; j < 3; j++) begin
            tick();
            check("sparse_idle_flag", 32'(flag_out), 32'd0);
         end
      end
      check("sparse_cnt", event_cnt, 32'h0001_0001);

      // Saturation on channel 1
      ce = 1'b1;
      for (int n = 0; n < 255; n++) begin
         toggle_in[1] = ~toggle_in[1];
         tick();
         tick();
      end
      tick();
      check("sat255_cnt", event_cnt, 32'h0001_FF01);
      check("sat255_ovf", 32'(overflow), 32'd0);
      toggle_in[1] = ~toggle_in[1];
      tick();
      tick();
      tick();
      check("sat256_flag", 32'(flag_out), 32'h2);
      check("sat256_cnt", event_cnt, 32'h0001_FF01);
      check("sat256_ovf", 32'(overflow), 32'h2);

      // Clear collision on channel 3 (plus a plain clear on channel 1)
      for (int n = 0; n < 5; n++) begin
         toggle_in[3] = ~toggle_in[3];
         tick();
         tick();
      end
      tick();
      check("ch3_five", event_cnt, 32'h0501_FF01);
      toggle_in[3] = ~toggle_in[3];
      tick();
      tick();
      cnt_clear = 4'b1010;
      tick();
      check("clr_coll_flag", 32'(flag_out), 32'h8);
      check("clr_coll_cnt", event_cnt, 32'h0101_0001);
      check("clr_coll_ovf", 32'(overflow), 32'd0);
      cnt_clear = 4'b1000;
      tick();
      check("clr_plain_cnt", event_cnt, 32'h0001_0001);
      ce = 1'b0;
      cnt_clear = 4'b0001;
      tick();
      check("clr_no_ce_cnt", event_cnt, 32'h0001_0000);
      cnt_clear = 4'b0000;

      // Reset while an event is in the chain
      ce = 1'b1;
      toggle_in[2] = ~toggle_in[2];
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("midrst_armed", 32'(armed), 32'd0);
      check("midrst_flag", 32'(flag_out), 32'd0);
      check("midrst_cnt", event_cnt, 32'd0);
      check("midrst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;
      tick();
      check("midrst_e1_armed", 32'(armed), 32'd0);
      tick();
      check("midrst_e2_armed", 32'(armed), 32'd0);
      tick();
      check("midrst_e3_armed", 32'(armed), 32'd1);
      check("midrst_e3_flag", 32'(flag_out), 32'd0);
      tick();
      check("midrst_e4_flag", 32'(flag_out), 32'd0);
      tick();
      check("midrst_e5_flag", 32'(flag_out), 32'd0);
      check("midrst_end_cnt", event_cnt, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/flag_sync_rx_multi.md
Name: flag_sync_rx_multi

Overview:
Multi-channel receiver for toggle-encoded flags. Each sending domain flips a toggle line once per event; this block brings those lines into the local CLK domain. Each channel has a SYNC_STAGES-deep synchroniser and edge detection, and emits a one-cycle FLAG_OUT per event, gated by a clock enable. Each channel also keeps a saturating event counter with a sticky overflow bit for status readback, and flags are suppressed until the synchronisers are primed after reset.

Parameters:
CHANNELS, 4, number of independent toggle inputs (>=1)
SYNC_STAGES, 3, synchroniser flops per channel (>=2)
CNT_WIDTH, 8, width of each per-channel event counter (>=1)

Ports:
CLK  input  1  single clock, all logic on posedge
RST  input  1  synchronous reset, active-high
CE  input  1  clock enable; synchroniser shift, priming and flag detection advance only when 1
TOGGLE_IN  input  CHANNELS  asynchronous toggle lines, one per channel; each edge is one event
FLAG_OUT  output  CHANNELS  registered one-CLK pulse per detected event
ANY_FLAG  output  1  combinational OR of FLAG_OUT
ARMED  output  1  high once priming has completed after reset
CNT_CLEAR  input  CHANNELS  per-channel clear of counter and overflow; not gated by CE
EVENT_CNT  output  CHANNELS*CNT_WIDTH  saturating counters; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH]
OVERFLOW  output  CHANNELS  sticky; set when an event arrives while the counter is saturated

Behaviour:
- Reset (RST=1 at a posedge): all synchroniser flops 0, priming counter 0, ARMED=0, FLAG_OUT=0, EVENT_CNT=0, OVERFLOW=0. Reset wins over every other input, including a mid-stream event.
- Synchroniser, per channel, stages s[0..SYNC_STAGES-1]:
  - On a CE=1 edge: s[0]<=TOGGLE_IN[i], s[k]<=s[k-1].
  - On a CE=0 edge: hold.
  - s[0] carries an async-register/no-SRL attribute so synthesis keeps the chain as flops.
- Priming:
  - Counter increments on each CE=1 edge while ARMED=0.
  - ARMED<=1 on the CE edge where the counter reaches SYNC_STAGES, i.e. after SYNC_STAGES CE edges following reset release.
  - ARMED stays 1 until the next RST.
  - Purpose: a TOGGLE_IN already at 1 during reset fills the chain without producing a spurious event.
- Detection:
  - On a CE=1 edge with ARMED=1: FLAG_OUT[i] <= s[SYNC_STAGES-2] ^ s[SYNC_STAGES-1], using pre-shift values.
  - Otherwise FLAG_OUT[i] <= 0.
  - Detect is evaluated on the ARMED value before the edge, so the edge that sets ARMED produces no flag.
  - FLAG_OUT is therefore high for exactly one CLK cycle even when CE pulses are sparse.
- Latency: with CE held at 1 and ARMED=1, a TOGGLE_IN change captured at edge 1 raises FLAG_OUT after edge SYNC_STAGES (3 edges by default). In general, latency is SYNC_STAGES CE edges.
- Input rate constraint: each TOGGLE_IN level must be held for at least 2 CE periods.
  - Two toggles inside one CE period cancel and are lost.
  - This is allowed behaviour, not an error.
- Counters, updated on the same edge that sets FLAG_OUT[i]:
  - CNT_CLEAR[i]=1 and event: count<=1, OVERFLOW<=0.
  - CNT_CLEAR[i]=1, no event: count<=0, OVERFLOW<=0.
  - Event with count < 2^CNT_WIDTH-1: count+1.
  - Event with count == 2^CNT_WIDTH-1: count holds, OVERFLOW[i]<=1.
  - No wrap-around ever.
- Channels are fully independent; simultaneous events on all channels are all flagged and all counted on the same edge.
- ANY_FLAG has no register: it is valid in the same cycle as FLAG_OUT.

Test Plan:
- Reset priming: hold TOGGLE_IN=4'b1111 through RST, release with CE=1 -> ARMED=1 after 3 edges; FLAG_OUT stays 0 throughout; EVENT_CNT all 0.
- Single event latency: ARMED=1, CE=1, flip TOGGLE_IN[2] 0->1 -> FLAG_OUT=4'b0100 for exactly one cycle, 3 edges after capture; EVENT_CNT ch2=1; ANY_FLAG=1 in the same cycle.
- Sparse CE: CE=1 every 4th cycle, flip TOGGLE_IN[0] -> FLAG_OUT[0] high one CLK cycle, following the 3rd CE edge after capture; no further flags.
- Saturation: CNT_WIDTH=8, apply 256 events on ch1 (each level held 2 CE periods) -> count=255, OVERFLOW[1]=0 after event 255 and 1 after event 256; other channels remain 0.
- Clear collision: ch3 count=5, assert CNT_CLEAR[3] on the edge FLAG_OUT[3] is set -> count=1, OVERFLOW[3]=0; clear with no event -> count=0.
- Reset mid-operation: pending toggle in the chain, then RST=1 for one cycle -> all outputs 0 and ARMED=0; event not emitted; re-priming takes 3 CE edges.
